// File: rtl/sobel_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sobel_pkg                                                                |
// | Shared definitions for the Sobel gradient pipeline: output-mode          |
// | encodings, kernel weights and a signed saturation helper.                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package sobel_pkg;

  // Output mode captured with each window. RSVD behaves like XY.
  typedef enum logic [1:0] {
    SOBEL_MODE_XY   = 2'd0,
    SOBEL_MODE_MAG  = 2'd1,
    SOBEL_MODE_EDGE = 2'd2,
    SOBEL_MODE_RSVD = 2'd3
  } sobel_mode_e;

  // Kernel weights: the outer taps of a Sobel row/column carry 1, the centre tap 2.
  // Gx = [-1 0 1; -2 0 2; -1 0 1], Gy = [-1 -2 -1; 0 0 0; 1 2 1].
  localparam int K_OUTER  = 1;
  localparam int K_CENTER = 2;

  // Guard bits over the pixel width so that |G| <= 4*(2**PIXW-1) is exact in
  // two's complement.
  localparam int SUM_GUARD = 4;

  // Clamp a signed value into the range of a w-bit two's complement number.
  // The caller truncates the result to w bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int                 w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_pix_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sobel_pix_counter                                                        |
// | Counts accepted output beats within a frame and flags the last one.      |
// | Ports: clk, reset (sync, active-high), valid_i/ready_i (output           |
// |        handshake), count_o (index of current beat), last_o (current      |
// |        valid beat is pixel PIXELS-1).                                    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sobel_pix_counter #(
  parameter int PIXELS = 1048576,
  parameter int PICW   = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            ready_i,
  output logic [PICW-1:0] count_o,
  output logic            last_o
);

  localparam logic [PICW-1:0] LAST_IDX = PICW'(PIXELS - 1);

  logic [PICW-1:0] count_q;
  logic [PICW-1:0] count_d;
  logic            at_last;

  assign at_last = (count_q == LAST_IDX);

  always_comb begin
    count_d = count_q;
    if (valid_i && ready_i) begin
      count_d = at_last ? '0 : count_q + PICW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Only meaningful alongside a valid beat; gating keeps it low through reset.
  assign last_o  = valid_i && at_last;

endmodule
`default_nettype wire

// File: rtl/sobel_grad_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sobel_grad_pipe                                                          |
// | Three-stage Sobel gradient pipeline with valid/ready backpressure.       |
// | S1: per-row partial sums, S2: full Gx/Gy, S3: saturate / magnitude /     |
// | edge select into the output registers.                                   |
// | Ports: clk, reset (sync, active-high); in_valid/in_ready with rowA/B/C   |
// |        (3 pixels each, left in the MSBs) and mode; out_valid/out_ready   |
// |        with gx, gy, mag, frame_last, pix_count.                          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sobel_grad_pipe
  import sobel_pkg::*;
#(
  parameter int PIXW   = 8,
  parameter int OUTW   = 9,
  parameter int PIXELS = 1048576,
  parameter int PICW   = 24,
  parameter int THRESH = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3*PIXW-1:0]      rowA,
  input  logic [3*PIXW-1:0]      rowB,
  input  logic [3*PIXW-1:0]      rowC,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OUTW-1:0] gx,
  output logic signed [OUTW-1:0] gy,
  output logic [OUTW-1:0]        mag,
  output logic                   frame_last,
  output logic [PICW-1:0]        pix_count
);

  localparam int                   SW      = PIXW + SUM_GUARD;
  localparam logic signed [SW-1:0] KO      = SW'(K_OUTER);
  localparam logic signed [SW-1:0] KC      = SW'(K_CENTER);
  localparam logic [31:0]          MAG_MAX = (32'd1 << OUTW) - 32'd1;

  // Zero-extend pixel `col` (0=left, 2=right) of a packed row into a signed sum.
  function automatic logic signed [SW-1:0] px(input logic [3*PIXW-1:0] row, input int col);
    return SW'({1'b0, row[(3-col)*PIXW-1 -: PIXW]});
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- S1: per-row partial sums ----------------
  logic signed [SW-1:0] gxa_d, gxb_d, gxc_d, gya_d, gyc_d;
  logic signed [SW-1:0] gxa_q, gxb_q, gxc_q, gya_q, gyc_q;
  sobel_mode_e          mode1_q;
  logic                 v1_q;

  always_comb begin
    gxa_d = KO * (px(rowA, 2) - px(rowA, 0));
    gxb_d = KC * (px(rowB, 2) - px(rowB, 0));
    gxc_d = KO * (px(rowC, 2) - px(rowC, 0));
    gya_d = KO * px(rowA, 0) + KC * px(rowA, 1) + KO * px(rowA, 2);
    gyc_d = KO * px(rowC, 0) + KC * px(rowC, 1) + KO * px(rowC, 2);
  end

  // ---------------- S2: full gradients ----------------
  logic signed [SW-1:0] gx2_d, gy2_d, gx2_q, gy2_q;
  sobel_mode_e          mode2_q;
  logic                 v2_q;

  assign gx2_d = gxa_q + gxb_q + gxc_q;
  assign gy2_d = gyc_q - gya_q;

  // ---------------- S3: saturate / magnitude / select ----------------
  // The magnitude is built from the exact gradients so a saturated Gx/Gy
  // never leaks into |Gx|+|Gy|.
  logic [SW-1:0]          absx, absy, msum;
  logic [31:0]            msum32;
  logic signed [31:0]     gx_sat, gy_sat;
  logic signed [OUTW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic [OUTW-1:0]        mag_d, mag_q;
  logic                   out_valid_q;

  assign absx   = gx2_q[SW-1] ? $unsigned(-gx2_q) : $unsigned(gx2_q);
  assign absy   = gy2_q[SW-1] ? $unsigned(-gy2_q) : $unsigned(gy2_q);
  assign msum   = absx + absy;
  assign msum32 = 32'(msum);
  assign gx_sat = sat_signed(32'(gx2_q), OUTW);
  assign gy_sat = sat_signed(32'(gy2_q), OUTW);

  always_comb begin
    gx_d  = '0;
    gy_d  = '0;
    mag_d = '0;
    case (mode2_q)
      SOBEL_MODE_MAG:  mag_d = (msum32 > MAG_MAX) ? OUTW'(MAG_MAX) : OUTW'(msum32);
      SOBEL_MODE_EDGE: mag_d = (msum32 >= $unsigned(THRESH)) ? '1 : '0;
      default: begin
        gx_d = OUTW'(gx_sat);
        gy_d = OUTW'(gy_sat);
      end
    endcase
  end

  // Datapath registers carry no reset; their valid bits decide relevance.
  always_ff @(posedge clk) begin
    if (advance) begin
      gxa_q   <= gxa_d;
      gxb_q   <= gxb_d;
      gxc_q   <= gxc_d;
      gya_q   <= gya_d;
      gyc_q   <= gyc_d;
      mode1_q <= sobel_mode_e'(mode);
      gx2_q   <= gx2_d;
      gy2_q   <= gy2_d;
      mode2_q <= mode1_q;
    end
  end

  // Valid chain and output registers; bubbles move with the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      mag_q       <= '0;
    end else if (advance) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      mag_q       <= mag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign gx        = gx_q;
  assign gy        = gy_q;
  assign mag       = mag_q;

  sobel_pix_counter #(
    .PIXELS (PIXELS),
    .PICW   (PICW)
  ) u_pix_cnt (
    .clk     (clk),
    .reset   (reset),
    .valid_i (out_valid_q),
    .ready_i (out_ready),
    .count_o (pix_count),
    .last_o  (frame_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_sobel_grad_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_sobel_grad_pipe                                                       |
// | Directed bench: a table of windows with hand-computed results, a         |
// | backpressured stream with frame wrap, and a mid-flight reset.            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sobel_grad_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] rowA, rowB, rowC;
  logic [1:0]  mode;
  logic        out_ready;

  logic              in_ready, out_valid, frame_last;
  logic signed [8:0] gx, gy;
  logic [8:0]        mag;
  logic [2:0]        pix_count;

  logic              in_ready4, out_valid4, frame_last4;
  logic signed [8:0] gx4, gy4;
  logic [8:0]        mag4;
  logic [2:0]        pix_count4;

  always #5 clk = ~clk;

  sobel_grad_pipe #(.PIXW(8), .OUTW(9), .PIXELS(4), .PICW(3), .THRESH(128)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rowA(rowA), .rowB(rowB), .rowC(rowC), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .gx(gx), .gy(gy), .mag(mag),
    .frame_last(frame_last), .pix_count(pix_count)
  );

  sobel_grad_pipe #(.PIXW(8), .OUTW(9), .PIXELS(4), .PICW(3), .THRESH(400)) u_dut_t400 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .rowA(rowA), .rowB(rowB), .rowC(rowC), .mode(mode),
    .out_valid(out_valid4), .out_ready(out_ready), .gx(gx4), .gy(gy4), .mag(mag4),
    .frame_last(frame_last4), .pix_count(pix_count4)
  );

  typedef struct {
    logic [23:0] ra;
    logic [23:0] rb;
    logic [23:0] rc;
    logic [1:0]  md;
    int          egx;
    int          egy;
    int          emag;
    int          emag4;
  } vec_t;

  localparam int NV = 16;
  vec_t tv [NV];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_vec(input int i);
    rowA = tv[i].ra;
    rowB = tv[i].rb;
    rowC = tv[i].rc;
    mode = tv[i].md;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          exp_q[$];
    int          sent, got, cyc, idx;
    logic        stalled_prev;
    logic signed [8:0] hgx, hgy;
    logic [8:0]  hmag;
    logic [3:0]  rdy_pat;

    //            rowA                         rowB                      rowC                       md    gx    gy   mag  mag@400
    tv[0]  = '{{8'd10,8'd20,8'd30},    {8'd40,8'd50,8'd60}, {8'd70,8'd80,8'd90},     2'd0,   80,  240,   0,   0};
    tv[1]  = '{{8'd10,8'd20,8'd30},    {8'd40,8'd50,8'd60}, {8'd70,8'd80,8'd90},     2'd1,    0,    0, 320, 320};
    tv[2]  = '{{8'd10,8'd20,8'd30},    {8'd40,8'd50,8'd60}, {8'd70,8'd80,8'd90},     2'd2,    0,    0, 511,   0};
    tv[3]  = '{{8'd10,8'd20,8'd30},    {8'd40,8'd50,8'd60}, {8'd70,8'd80,8'd90},     2'd3,   80,  240,   0,   0};
    tv[4]  = '{{8'd0,8'd0,8'd255},     {8'd0,8'd0,8'd255},  {8'd0,8'd0,8'd255},      2'd0,  255,    0,   0,   0};
    tv[5]  = '{{8'd0,8'd0,8'd255},     {8'd0,8'd0,8'd255},  {8'd0,8'd0,8'd255},      2'd1,    0,    0, 511, 511};
    tv[6]  = '{{8'd255,8'd0,8'd0},     {8'd255,8'd0,8'd0},  {8'd255,8'd0,8'd0},      2'd0, -256,    0,   0,   0};
    tv[7]  = '{{8'd255,8'd255,8'd255}, 24'd0,               24'd0,                   2'd0,    0, -256,   0,   0};
    tv[8]  = '{24'd0,                  24'd0,               {8'd1,8'd127,8'd0},      2'd0,   -1,  255,   0,   0};
    tv[9]  = '{24'd0,                  24'd0,               {8'd0,8'd128,8'd0},      2'd0,    0,  255,   0,   0};
    tv[10] = '{24'd0,                  24'd0,               {8'd0,8'd128,8'd0},      2'd1,    0,    0, 256, 256};
    tv[11] = '{24'd0,                  24'd0,               {8'd0,8'd63,8'd0},       2'd2,    0,    0,   0,   0};
    tv[12] = '{24'd0,                  24'd0,               {8'd0,8'd64,8'd0},       2'd2,    0,    0, 511,   0};
    tv[13] = '{24'd0,                  24'd0,               {8'd0,8'd255,8'd0},      2'd1,    0,    0, 510, 510};
    tv[14] = '{24'd0,                  24'd0,               {8'd0,8'd255,8'd1},      2'd1,    0,    0, 511, 511};
    tv[15] = '{24'd0,                  24'd0,               {8'd0,8'd200,8'd0},      2'd2,    0,    0, 511, 511};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rowA = '0; rowB = '0; rowC = '0; mode = 2'd0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_gx", int'(gx), 0);
    check("rst_gy", int'(gy), 0);
    check("rst_mag", int'(mag), 0);
    check("rst_frame_last", int'(frame_last), 0);
    check("rst_pix_count", int'(pix_count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_t400_state", int'({out_valid4, frame_last4, pix_count4}), 0);
    check("rst_t400_in_ready", int'(in_ready4), 1);

    // ---- single windows: exact latency and values ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_vec(i);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("tv%0d_early_valid", i), int'(out_valid), 0);
      @(negedge clk);
      check($sformatf("tv%0d_valid", i), int'(out_valid), 1);
      check($sformatf("tv%0d_gx", i), int'(gx), tv[i].egx);
      check($sformatf("tv%0d_gy", i), int'(gy), tv[i].egy);
      check($sformatf("tv%0d_mag", i), int'(mag), tv[i].emag);
      check($sformatf("tv%0d_t400_gxgy", i), int'(gx4) + int'(gy4), tv[i].egx + tv[i].egy);
      check($sformatf("tv%0d_t400_mag", i), int'(mag4), tv[i].emag4);
    end

    // ---- backpressured stream of 10 beats with frame wrap ----
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rdy_pat = 4'b1001; // per-cycle out_ready: 1,0,0,1
    sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0;
    hgx = '0; hgy = '0; hmag = '0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      if (stalled_prev) begin
        check($sformatf("stall%0d_hold", cyc),
              int'({out_valid, gx, gy, mag}), int'({1'b1, hgx, hgy, hmag}));
      end
      out_ready = rdy_pat[3 - (cyc % 4)];
      in_valid  = (sent < 10);
      if (sent < 10) drive_vec(sent);
      #1;
      check($sformatf("cyc%0d_in_ready", cyc), int'(in_ready), int'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("cyc%0d_unexpected_beat", cyc), 1, 0);
        end else begin
          idx = exp_q.pop_front();
          check($sformatf("beat%0d_gx", got), int'(gx), tv[idx].egx);
          check($sformatf("beat%0d_gy", got), int'(gy), tv[idx].egy);
          check($sformatf("beat%0d_mag", got), int'(mag), tv[idx].emag);
          check($sformatf("beat%0d_pix_count", got), int'(pix_count), got % 4);
          check($sformatf("beat%0d_frame_last", got), int'(frame_last), int'((got % 4) == 3));
        end
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      hgx = gx; hgy = gy; hmag = mag;
      if (in_valid && in_ready) begin
        exp_q.push_back(sent);
        sent++;
      end
      cyc++;
    end
    check("stream_beats_out", got, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("stream_no_extra_beat", int'(out_valid), 0);

    // ---- reset with three beats in flight ----
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_vec(k + 4);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_valid", int'(out_valid), 1);
    check("pre_reset_pix_count", int'(pix_count), 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_valid", int'(out_valid), 0);
    check("post_reset_pix_count", int'(pix_count), 0);
    check("post_reset_outputs", int'({frame_last, gx, gy, mag}), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("dropped%0d_valid", k), int'(out_valid), 0);
    end
    drive_vec(0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("after_reset_early_valid", int'(out_valid), 0);
    @(negedge clk);
    check("after_reset_valid", int'(out_valid), 1);
    check("after_reset_pix_count", int'(pix_count), 0);
    check("after_reset_gx", int'(gx), 80);
    check("after_reset_gy", int'(gy), 240);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
